// File: rtl/fact_iter_pkg.sv
// fact_iter_pkg: FSM encoding and sizing helpers shared by the factorial engine files.
package fact_iter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MUL   = 3'd2,
    ST_UPD   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fact_iter_mul.sv
// fact_iter_mul: WIDTH x WIDTH shift-add multiplier, one partial product per cycle.
// done is high during the final step, so prod is complete on the following cycle.
module fact_iter_mul
  import fact_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      bitcnt_r;
  logic               run_r;

  // Load operands on start, then consume one multiplier bit per cycle for WIDTH cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      bitcnt_r <= {CW{1'b0}};
      run_r    <= 1'b0;
    end else if (start) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      prod_r   <= {(2*WIDTH){1'b0}};
      mplier_r <= b;
      bitcnt_r <= {CW{1'b0}};
      run_r    <= 1'b1;
    end else if (run_r) begin
      if (mplier_r[0]) begin
        prod_r <= prod_r + mcand_r;
      end
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      bitcnt_r <= bitcnt_r + BIT_ONE;
      run_r    <= (bitcnt_r != LAST_BIT);
    end
  end

  assign done = run_r && (bitcnt_r == LAST_BIT);
  assign prod = prod_r;

endmodule

// File: rtl/fact_iter.sv
// fact_iter: iterative n! engine with go/busy/done/err handshake and true overflow detection.
// Optional abort input is enabled by defining FACT_ITER_ABORT_EN.
module fact_iter
  import fact_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
`ifdef FACT_ITER_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] nf
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state_r, state_nx_s;
  logic [WIDTH-1:0]   cnt_r, acc_r, nf_r;
  logic               busy_r, done_r, err_r;
  logic               abort_s, small_s, ovf_s, mul_start_s, mul_done_s;
  logic [2*WIDTH-1:0] prod_s;

`ifdef FACT_ITER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign small_s     = (cnt_r <= ONE);
  assign ovf_s       = |prod_s[2*WIDTH-1:WIDTH];
  assign mul_start_s = (state_r == ST_CHECK) && !small_s && !abort_s;

  fact_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start_s),
    .a     (acc_r),
    .b     (cnt_r),
    .done  (mul_done_s),
    .prod  (prod_s)
  );

  // Next-state selection; abort wins over any in-flight transition
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (go) state_nx_s = ST_CHECK;
        else    state_nx_s = state_r;
      end
      ST_CHECK: begin
        if (abort_s)      state_nx_s = ST_IDLE;
        else if (small_s) state_nx_s = ST_DONE;
        else              state_nx_s = ST_MUL;
      end
      ST_MUL: begin
        if (abort_s)         state_nx_s = ST_IDLE;
        else if (mul_done_s) state_nx_s = ST_UPD;
        else                 state_nx_s = ST_MUL;
      end
      ST_UPD: begin
        if (abort_s)    state_nx_s = ST_IDLE;
        else if (ovf_s) state_nx_s = ST_ERR;
        else            state_nx_s = ST_CHECK;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, iteration registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      nf_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == ST_CHECK) || (state_nx_s == ST_MUL) || (state_nx_s == ST_UPD);
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (go) begin
            cnt_r  <= n;
            acc_r  <= ONE;
            nf_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (small_s && !abort_s) begin
            nf_r   <= acc_r;
            done_r <= 1'b1;
          end
        end
        ST_UPD: begin
          // nf stays zero on overflow; done/err/nf were already cleared at go
          if (!abort_s) begin
            if (ovf_s) begin
              err_r <= 1'b1;
            end else begin
              acc_r <= prod_s[WIDTH-1:0];
              cnt_r <= cnt_r - ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;
  assign nf   = nf_r;

endmodule

// File: tb/tb_fact_iter.sv
// tb_fact_iter: directed and random checks of fact_iter at WIDTH=32 and WIDTH=16
// against an arithmetic factorial/latency model.
module tb_fact_iter;

  localparam int LIMIT = 5000;

  logic        clk = 1'b0;
  logic        rst;
  logic        go32, go16;
  logic [31:0] n32;
  logic [15:0] n16;
  logic        busy32, done32, err32;
  logic [31:0] nf32;
  logic        busy16, done16, err16;
  logic [15:0] nf16;
`ifdef FACT_ITER_ABORT_EN
  logic        abort32;
  logic        abort16 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fact_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .go(go32),
`ifdef FACT_ITER_ABORT_EN
    .abort(abort32),
`endif
    .n(n32), .busy(busy32), .done(done32), .err(err32), .nf(nf32)
  );

  fact_iter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16),
`ifdef FACT_ITER_ABORT_EN
    .abort(abort16),
`endif
    .n(n16), .busy(busy16), .done(done16), .err(err16), .nf(nf16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd_nf(input bit w16);
    return w16 ? {48'd0, nf16} : {32'd0, nf32};
  endfunction
  function automatic logic rd_busy(input bit w16);
    return w16 ? busy16 : busy32;
  endfunction
  function automatic logic rd_done(input bit w16);
    return w16 ? done16 : done32;
  endfunction
  function automatic logic rd_err(input bit w16);
    return w16 ? err16 : err32;
  endfunction

  // Reference: descending product n*(n-1)*...*2 starting from 1, stop at first overflow.
  task automatic model(input int w, input logic [63:0] nv, output bit ovf,
                       output logic [63:0] res, output int lat);
    logic [127:0]    p;
    longint unsigned c;
    int              k;
    p = 128'd1; ovf = 1'b0; k = 0; c = nv;
    while (c > 1 && !ovf) begin
      k++;
      p = p * c;
      if ((p >> w) != 128'd0) ovf = 1'b1;
      else c--;
    end
    if (ovf) begin
      res = 64'd0;
      lat = 1 + k * (w + 2);
    end else begin
      res = p[63:0];
      lat = (k == 0) ? 2 : 2 + k * (w + 2);
    end
  endtask

  // Launch one computation, optionally pulse a second go while busy, check result and hold.
  task automatic run_op(input bit w16, input logic [63:0] nv_in, input string tag,
                        input int inject_at, input logic [63:0] inject_n);
    bit          ovf;
    logic [63:0] nv, exp_nf;
    int          exp_lat, cyc;
    nv = w16 ? {48'd0, nv_in[15:0]} : {32'd0, nv_in[31:0]};
    model(w16 ? 16 : 32, nv, ovf, exp_nf, exp_lat);
    if (w16) begin go16 = 1'b1; n16 = nv[15:0]; end
    else     begin go32 = 1'b1; n32 = nv[31:0]; end
    @(posedge clk); #1;
    go16 = 1'b0; go32 = 1'b0;
    check({tag, ".busy_after_go"}, rd_busy(w16), 64'd1);
    check({tag, ".done_cleared"}, rd_done(w16), 64'd0);
    cyc = 1;
    while (cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == inject_at) begin
        if (w16) begin go16 = 1'b1; n16 = inject_n[15:0]; end
        else     begin go32 = 1'b1; n32 = inject_n[31:0]; end
      end else begin
        go16 = 1'b0; go32 = 1'b0;
      end
      if (rd_done(w16) || rd_err(w16)) break;
    end
    go16 = 1'b0; go32 = 1'b0;
    check({tag, ".no_timeout"}, 64'(cyc < LIMIT), 64'd1);
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".done"}, rd_done(w16), 64'(!ovf));
    check({tag, ".err"}, rd_err(w16), 64'(ovf));
    check({tag, ".nf"}, rd_nf(w16), exp_nf);
    check({tag, ".busy_at_end"}, rd_busy(w16), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".nf_hold"}, rd_nf(w16), exp_nf);
    check({tag, ".done_hold"}, rd_done(w16), 64'(!ovf));
  endtask

  initial begin
    rst = 1'b1; go32 = 1'b0; go16 = 1'b0; n32 = 32'd0; n16 = 16'd0;
`ifdef FACT_ITER_ABORT_EN
    abort32 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy32", busy32, 64'd0);
    check("rst.done32", done32, 64'd0);
    check("rst.err32", err32, 64'd0);
    check("rst.nf32", {32'd0, nf32}, 64'd0);
    check("rst.busy16", busy16, 64'd0);
    check("rst.nf16", {48'd0, nf16}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted in the middle of a long multiply
    go32 = 1'b1; n32 = 32'd10;
    @(posedge clk); #1;
    go32 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst.busy_before", busy32, 64'd1);
    rst = 1'b1;
    #1;
    check("midrst.busy", busy32, 64'd0);
    check("midrst.done", done32, 64'd0);
    check("midrst.err", err32, 64'd0);
    check("midrst.nf", {32'd0, nf32}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst.idle", busy32, 64'd0);
    run_op(1'b0, 64'd4, "n4_after_rst", -1, 64'd0);

    run_op(1'b0, 64'd0, "w32_n0", -1, 64'd0);
    run_op(1'b0, 64'd1, "w32_n1", -1, 64'd0);
    run_op(1'b0, 64'd5, "w32_n5", -1, 64'd0);
    run_op(1'b0, 64'd12, "w32_n12", -1, 64'd0);
    run_op(1'b0, 64'd13, "w32_n13_ovf", -1, 64'd0);
    run_op(1'b1, 64'd8, "w16_n8", -1, 64'd0);
    run_op(1'b1, 64'd9, "w16_n9_ovf", -1, 64'd0);

    // go while busy is ignored; go while in DONE relaunches
    run_op(1'b0, 64'd6, "hs_go_while_busy", 10, 64'd3);
    run_op(1'b0, 64'd4, "hs_go_in_done", -1, 64'd0);

`ifdef FACT_ITER_ABORT_EN
    go32 = 1'b1; n32 = 32'd7;
    @(posedge clk); #1;
    go32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    check("abort.busy", busy32, 64'd0);
    check("abort.done", done32, 64'd0);
    check("abort.err", err32, 64'd0);
    check("abort.nf", {32'd0, nf32}, 64'd0);
    run_op(1'b0, 64'd3, "abort_then_n3", -1, 64'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, 64'($urandom_range(0, 14)), $sformatf("rnd32_%0d", i), -1, 64'd0);
    end
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 64'($urandom), $sformatf("rnd32big_%0d", i), -1, 64'd0);
    end
    for (int i = 0; i < 6; i++) begin
      run_op(1'b1, 64'($urandom_range(0, 10)), $sformatf("rnd16_%0d", i), -1, 64'd0);
    end
    run_op(1'b1, 64'($urandom_range(0, 65535)), "rnd16big", -1, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_iter.md
# fact_iter

Iterative, width-parametrised factorial engine that computes n! for any n using a sequential shift-add multiplier. It reports genuine arithmetic overflow against WIDTH rather than relying on a fixed input limit. It sits on the peripheral bus side as a memory-mapped accelerator, driven by a go/busy/done/err handshake from the processor-facing register wrapper.

## Interface
- WIDTH, 32: operand and result width in bits; legal range 4..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- go  input  1  start request; sampled only when not busy.
- n  input  WIDTH  unsigned operand; captured on the accepted go.
- busy  output  1  high while a computation is in flight.
- done  output  1  level; high when a valid result is on nf.
- err  output  1  level; high when n! overflowed WIDTH bits.
- nf  output  WIDTH  result; valid only while done=1.
- abort  input  1  present only with FACT_ITER_ABORT_EN.

## Operation
- Registers: cnt (WIDTH), acc (WIDTH), mcand (2·WIDTH), mplier (WIDTH), prod (2·WIDTH), bit counter (clog2(WIDTH)+1).
- States: IDLE, CHECK, MUL, UPD, DONE, ERR.
- IDLE/DONE/ERR with go=1: cnt←n, acc←1, done←0, err←0, nf←0, go to CHECK. go is ignored in every other state.
- CHECK: if cnt≤1, nf←acc, done←1, go to DONE. Otherwise mcand←{0,acc}, mplier←cnt, prod←0, bitcnt←0, go to MUL.
- MUL: runs exactly WIDTH cycles. Each cycle: if mplier[0], prod←prod+mcand. Then mcand←mcand<<1, mplier←mplier>>1.
- UPD: if prod[2W-1:W]≠0, err←1 and go to ERR (nf stays 0). Otherwise acc←prod[W-1:0], cnt←cnt−1, go to CHECK.
- Results: n=0 and n=1 both give nf=1. Operand order is descending (n·(n−1)·…·2).
- DONE/ERR hold their outputs until the next accepted go.
- busy=1 in CHECK, MUL and UPD; busy=0 otherwise.
- Reset values: state IDLE; busy=0, done=0, err=0, nf=0; all internal registers 0.
- Reset mid-computation discards all work and returns to IDLE immediately.

## Timing
- go is accepted on clock edge E0. busy is high from E0 until the edge that enters DONE or ERR.
- Latency to done: 2 + (n−1)·(WIDTH+2) cycles for n≥2, and 2 cycles for n≤1. Example: n=5, WIDTH=32 gives 138 cycles.
- Latency to err: 1 + k·(WIDTH+2) cycles, where k is the index of the first overflowing multiply.
- done and err are never high together. busy and done are never high together.
- go held high continuously re-launches on the cycle after DONE/ERR is entered. The result is visible for one cycle only; this is legal behaviour.
- No combinational path from inputs to outputs.

## Configuration
- FACT_ITER_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in CHECK, MUL or UPD returns the block to IDLE on the next edge with done=0, err=0, nf=0.
  - abort has priority over the state transition in that cycle.
  - abort is ignored in IDLE, DONE and ERR.
- FACT_ITER_ABORT_EN undefined: no abort port exists, and an accepted computation always runs to DONE or ERR.

## Structure
- Package fact_iter_pkg holds:
  - the state_t enum;
  - the localparam function for counter width (clog2(WIDTH)+1).
- One sub-module, fact_iter_mul: WIDTH×WIDTH sequential shift-add multiplier.
  - Inputs: start, a, b. Outputs: done pulse, 2·WIDTH product.
  - Owns mcand, mplier, prod and bitcnt.
- The fact_iter top holds the FSM, cnt, acc and the output registers.

## Test plan
- Reset: assert rst mid-MUL on a WIDTH=32, n=10 run → all outputs 0 in the same cycle, state IDLE. A following go with n=4 → nf=24, done=1.
- Small operands: WIDTH=32, n=0 and n=1 → nf=1, done after exactly 2 cycles, err=0.
- Nominal: WIDTH=32, n=5 → nf=120, done exactly 138 cycles after go. n=12 → nf=479001600, err=0.
- Overflow: WIDTH=32, n=13 → err=1, done=0, nf=0. WIDTH=16, n=8 → nf=40320; n=9 → err=1.
- Handshake: pulse go again while busy with a different n → ignored, first result unchanged. go in DONE → done drops the next cycle and the new result follows.
- FACT_ITER_ABORT_EN: abort during MUL of n=7 → IDLE next edge with done=0, err=0. A following go with n=3 → nf=6.
